// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: shares one single-port RAM between display scan-out
// reads and NREQ pixel clients (watchdog > display > round-robin).
module fb_port_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 19,
  parameter int DW       = 24,
  parameter int FB_DEPTH = 76800,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               disp_req,
  input  logic [AW-1:0]      disp_addr,
  output logic               disp_rvalid,
  output logic [DW-1:0]      disp_rdata,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic               rd_valid,
  output logic [1:0]         rd_id,
  output logic [DW-1:0]      rd_data,
  output logic [AW-1:0]      fb_addr,
  output logic               fb_we,
  output logic [DW-1:0]      fb_wdata,
  input  logic [DW-1:0]      fb_rdata,
  output logic               disp_miss,
  output logic               err_oob
);

  localparam int IW = 2;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [AW-1:0] DEPTH_A  = AW'(FB_DEPTH);

  typedef struct packed {
    logic          v;
    logic          disp;
    logic [IW-1:0] id;
  } tag_t;

  logic [AW-1:0] cl_addr   [NREQ];
  logic [DW-1:0] cl_wdata  [NREQ];
  logic [WW-1:0] wait_reg  [NREQ];
  logic [WW-1:0] wait_next [NREQ];

  logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
  logic          wd_hit, rr_hit;
  logic [IW-1:0] wd_idx, rr_idx;
  int            cand;

  logic          gnt_disp, gnt_cl;
  logic [IW-1:0] gnt_idx;
  logic          sel_we, sel_oob;
  logic [AW-1:0] sel_addr;

  logic [AW-1:0] fb_addr_reg;
  logic          fb_we_reg;
  logic [DW-1:0] fb_wdata_reg;
  logic          disp_miss_reg, disp_miss_next;
  logic          err_oob_reg, err_oob_next;

  tag_t          pipe_reg [RD_LAT+1];
  tag_t          pipe_in, pipe_out;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_client
      assign cl_addr[gi]   = req_addr[gi*AW +: AW];
      assign cl_wdata[gi]  = req_wdata[gi*DW +: DW];
      assign req_ready[gi] = gnt_cl && (gnt_idx == IW'(gi));
      // Counter only runs while the client is actually waiting; saturates at the threshold.
      assign wait_next[gi] = (req_valid[gi] && !req_ready[gi])
                             ? ((wait_reg[gi] == WAIT_MAX) ? WAIT_MAX : wait_reg[gi] + WW'(1))
                             : '0;
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREQ; i++) wait_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) wait_reg[i] <= wait_next[i];
    end
  end

  // Candidate search: watchdog scans downward so the lowest index wins ties.
  always_comb begin
    wd_hit = 1'b0;
    wd_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && wait_reg[i] == WAIT_MAX) begin
        wd_hit = 1'b1;
        wd_idx = IW'(i);
      end
    end
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_ptr_reg) + k) % NREQ;
      if (!rr_hit && req_valid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    gnt_disp    = 1'b0;
    gnt_cl      = 1'b0;
    gnt_idx     = '0;
    rr_ptr_next = rr_ptr_reg;
    if (wd_hit) begin
      gnt_cl  = 1'b1;
      gnt_idx = wd_idx;
    end else if (disp_req) begin
      gnt_disp = 1'b1;
    end else if (rr_hit) begin
      gnt_cl      = 1'b1;
      gnt_idx     = rr_idx;
      rr_ptr_next = rr_idx;
    end
  end

  assign sel_we   = gnt_cl && req_we[gnt_idx];
  assign sel_addr = gnt_disp ? disp_addr : cl_addr[gnt_idx];
  assign sel_oob  = (sel_addr >= DEPTH_A);

  // Set beats the frame_start clear when both land in the same cycle.
  assign disp_miss_next = (wd_hit && disp_req) ? 1'b1 : (frame_start ? 1'b0 : disp_miss_reg);
  assign err_oob_next   = (sel_we && sel_oob)  ? 1'b1 : (frame_start ? 1'b0 : err_oob_reg);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr_reg    <= IW'(NREQ - 1);
      fb_addr_reg   <= '0;
      fb_we_reg     <= 1'b0;
      fb_wdata_reg  <= '0;
      disp_miss_reg <= 1'b0;
      err_oob_reg   <= 1'b0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      fb_we_reg     <= sel_we && !sel_oob;
      if (gnt_cl || gnt_disp) fb_addr_reg <= sel_addr;
      if (sel_we) fb_wdata_reg <= cl_wdata[gnt_idx];
      disp_miss_reg <= disp_miss_next;
      err_oob_reg   <= err_oob_next;
    end
  end

  // Read tags travel alongside the RAM access so the last stage lines up with fb_rdata.
  assign pipe_in = '{v: gnt_disp || (gnt_cl && !req_we[gnt_idx]), disp: gnt_disp, id: gnt_idx};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int s = 0; s <= RD_LAT; s++) pipe_reg[s] <= '0;
    end else begin
      pipe_reg[0] <= pipe_in;
      for (int s = 1; s <= RD_LAT; s++) pipe_reg[s] <= pipe_reg[s-1];
    end
  end

  assign pipe_out    = pipe_reg[RD_LAT];
  assign disp_rvalid = pipe_out.v && pipe_out.disp;
  assign rd_valid    = pipe_out.v && !pipe_out.disp;
  assign disp_rdata  = disp_rvalid ? fb_rdata : '0;
  assign rd_data     = rd_valid ? fb_rdata : '0;
  assign rd_id       = rd_valid ? pipe_out.id : '0;

  assign fb_addr   = fb_addr_reg;
  assign fb_we     = fb_we_reg;
  assign fb_wdata  = fb_wdata_reg;
  assign disp_miss = disp_miss_reg;
  assign err_oob   = err_oob_reg;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: grant vectors from a table, read returns checked
// against a scoreboard queue, plus hand-written reset/watchdog/error sequences.
module tb_fb_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic        disp_rvalid;
  logic [23:0] disp_rdata;
  logic [2:0]  req_valid;
  logic [2:0]  req_we;
  logic [18:0] cl_addr [3];
  logic [23:0] cl_wdata [3];
  logic [56:0] req_addr;
  logic [71:0] req_wdata;
  logic [2:0]  req_ready;
  logic        rd_valid;
  logic [1:0]  rd_id;
  logic [23:0] rd_data;
  logic [18:0] fb_addr;
  logic        fb_we;
  logic [23:0] fb_wdata;
  logic [23:0] fb_rdata;
  logic        disp_miss;
  logic        err_oob;

  assign req_addr  = {cl_addr[2], cl_addr[1], cl_addr[0]};
  assign req_wdata = {cl_wdata[2], cl_wdata[1], cl_wdata[0]};

  fb_port_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
    .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata),
    .disp_miss(disp_miss), .err_oob(err_oob)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // RAM model with 1-cycle read latency, plus the bench's own view of its contents.
  logic [23:0] ram    [131072];
  logic [23:0] shadow [131072];
  always @(posedge Clk) begin
    if (fb_we) ram[fb_addr[16:0]] <= fb_wdata;
    fb_rdata <= ram[fb_addr[16:0]];
  end

  function automatic logic [23:0] pat(input int a);
    logic [23:0] av;
    av = 24'(a);
    return 24'h9C0F0F ^ av ^ {av[7:0], 16'h0};
  endfunction

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic       disp;
    logic [1:0] id;
    logic [23:0] data;
    int         due;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  logic mon_ok;
  logic mon_en = 1'b0;
  logic [18:0] last_addr = '0;

  always @(negedge Clk) begin
    if (mon_en) begin
      if (sbq.size() != 0 && sbq[0].due == cyc) begin
        mon_e = sbq.pop_front();
        tests++;
        if (mon_e.disp)
          mon_ok = (disp_rvalid === 1'b1) && (rd_valid === 1'b0) && (disp_rdata === mon_e.data);
        else
          mon_ok = (rd_valid === 1'b1) && (disp_rvalid === 1'b0) && (rd_id === mon_e.id) && (rd_data === mon_e.data);
        if (!mon_ok) begin
          errors++;
          $display("FAIL rd_return cyc=%0d: got disp_rvalid=%b disp_rdata=%h rd_valid=%b rd_id=%0d rd_data=%h, expected disp=%b id=%0d data=%h",
                   cyc, disp_rvalid, disp_rdata, rd_valid, rd_id, rd_data, mon_e.disp, mon_e.id, mon_e.data);
        end
      end else begin
        tests++;
        if (disp_rvalid !== 1'b0 || rd_valid !== 1'b0) begin
          errors++;
          $display("FAIL no_spurious cyc=%0d: got disp_rvalid=%b rd_valid=%b, expected 0/0", cyc, disp_rvalid, rd_valid);
        end
      end
    end
  end

  // Inputs are already driven (just after a negedge). Checks the grant, predicts the
  // RAM drive and read return, then runs to the next negedge.
  task automatic tick(input logic [2:0] exp_ready, input logic exp_dgnt, input string nm);
    logic        exp_we;
    logic [18:0] exp_addr;
    logic [23:0] exp_wd;
    exp_t        e;
    exp_we   = 1'b0;
    exp_addr = last_addr;
    exp_wd   = '0;
    #1;
    tests++;
    if (req_ready !== exp_ready) begin
      errors++;
      $display("FAIL %s req_ready: got %b expected %b", nm, req_ready, exp_ready);
    end
    if (exp_dgnt) begin
      exp_addr = disp_addr;
      e = '{disp: 1'b1, id: 2'd0, data: shadow[disp_addr[16:0]], due: cyc + 2};
      sbq.push_back(e);
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (exp_ready[i]) begin
          exp_addr = cl_addr[i];
          if (req_we[i]) begin
            if (cl_addr[i] < 19'd76800) begin
              exp_we = 1'b1;
              exp_wd = cl_wdata[i];
              shadow[cl_addr[i][16:0]] = cl_wdata[i];
            end
          end else begin
            e = '{disp: 1'b0, id: 2'(i), data: shadow[cl_addr[i][16:0]], due: cyc + 2};
            sbq.push_back(e);
          end
        end
      end
    end
    @(posedge Clk);
    #1;
    tests++;
    if (fb_we !== exp_we || fb_addr !== exp_addr || (exp_we && fb_wdata !== exp_wd)) begin
      errors++;
      $display("FAIL %s fb_drive: got we=%b addr=%0d wdata=%h expected we=%b addr=%0d wdata=%h",
               nm, fb_we, fb_addr, fb_wdata, exp_we, exp_addr, exp_wd);
    end
    last_addr = exp_addr;
    @(negedge Clk);
  endtask

  task automatic check1(input string nm, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    tests++;
    if ({disp_rvalid, disp_rdata, req_ready, rd_valid, rd_id, rd_data,
         fb_addr, fb_we, fb_wdata, disp_miss, err_oob} !== '0) begin
      errors++;
      $display("FAIL %s outputs: got drv=%b drd=%h rdy=%b rv=%b id=%0d rd=%h fa=%0d fwe=%b fwd=%h miss=%b oob=%b, expected all 0",
               nm, disp_rvalid, disp_rdata, req_ready, rd_valid, rd_id, rd_data,
               fb_addr, fb_we, fb_wdata, disp_miss, err_oob);
    end
  endtask

  typedef struct {
    logic        dr;
    logic [18:0] da;
    logic [2:0]  v;
    logic [2:0]  we;
    logic [2:0]  exp_ready;
    logic        exp_dgnt;
  } vec_t;
  vec_t vecs [16];

  initial begin
    // Rows run back to back from reset (RR pointer starts at 2).
    vecs[0]  = '{1'b0, 19'd0,   3'b111, 3'b111, 3'b001, 1'b0};
    vecs[1]  = '{1'b0, 19'd0,   3'b111, 3'b111, 3'b010, 1'b0};
    vecs[2]  = '{1'b0, 19'd0,   3'b111, 3'b111, 3'b100, 1'b0};
    vecs[3]  = '{1'b0, 19'd0,   3'b111, 3'b111, 3'b001, 1'b0};
    vecs[4]  = '{1'b0, 19'd0,   3'b111, 3'b111, 3'b010, 1'b0};
    vecs[5]  = '{1'b0, 19'd0,   3'b111, 3'b111, 3'b100, 1'b0};
    vecs[6]  = '{1'b1, 19'd100, 3'b001, 3'b000, 3'b000, 1'b1};
    vecs[7]  = '{1'b0, 19'd100, 3'b001, 3'b000, 3'b001, 1'b0};
    vecs[8]  = '{1'b0, 19'd0,   3'b110, 3'b010, 3'b010, 1'b0};
    vecs[9]  = '{1'b0, 19'd0,   3'b110, 3'b010, 3'b100, 1'b0};
    vecs[10] = '{1'b0, 19'd0,   3'b011, 3'b000, 3'b001, 1'b0};
    vecs[11] = '{1'b0, 19'd0,   3'b000, 3'b000, 3'b000, 1'b0};
    vecs[12] = '{1'b1, 19'd7,   3'b000, 3'b000, 3'b000, 1'b1};
    vecs[13] = '{1'b1, 19'd8,   3'b110, 3'b000, 3'b000, 1'b1};
    vecs[14] = '{1'b0, 19'd0,   3'b110, 3'b000, 3'b010, 1'b0};
    vecs[15] = '{1'b0, 19'd0,   3'b101, 3'b101, 3'b100, 1'b0};

    for (int a = 0; a < 131072; a++) begin
      ram[a]    = pat(a);
      shadow[a] = pat(a);
    end

    Reset_n = 1'b0;
    frame_start = 1'b0;
    disp_req = 1'b0;
    disp_addr = '0;
    req_valid = '0;
    req_we = '0;
    for (int i = 0; i < 3; i++) begin
      cl_addr[i]  = 19'(300 + 10 * i);
      cl_wdata[i] = 24'h110000 * 24'(i + 1) + 24'h0000A5;
    end

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_zero("reset_init");
    Reset_n = 1'b1;
    mon_en  = 1'b1;

    // Grant table: RR fairness, display priority, mixed traffic.
    for (int i = 0; i < 16; i++) begin
      disp_req  = vecs[i].dr;
      disp_addr = vecs[i].da;
      req_valid = vecs[i].v;
      req_we    = vecs[i].we;
      tick(vecs[i].exp_ready, vecs[i].exp_dgnt, $sformatf("vec%0d", i));
    end
    disp_req  = 1'b0;
    req_valid = '0;
    req_we    = '0;

    // Read tagging: client 1 then client 0, back to back.
    cl_addr[1] = 19'd5;
    req_valid  = 3'b010;
    tick(3'b010, 1'b0, "tag_c1");
    cl_addr[0] = 19'd6;
    req_valid  = 3'b001;
    tick(3'b001, 1'b0, "tag_c0");
    req_valid = '0;
    tick(3'b000, 1'b0, "tag_idle");

    // Watchdog pre-empts a continuous display stream after 15 wait cycles.
    check1("miss_before", disp_miss, 1'b0);
    disp_req   = 1'b1;
    disp_addr  = 19'd50;
    cl_addr[1] = 19'd400;
    req_valid  = 3'b010;
    req_we     = 3'b010;
    for (int k = 0; k < 15; k++) tick(3'b000, 1'b1, $sformatf("wd_wait%0d", k));
    tick(3'b010, 1'b0, "wd_grant");
    check1("miss_set", disp_miss, 1'b1);
    req_valid = '0;
    req_we    = '0;
    tick(3'b000, 1'b1, "wd_disp_resume");
    check1("miss_hold", disp_miss, 1'b1);
    disp_req    = 1'b0;
    frame_start = 1'b1;
    tick(3'b000, 1'b0, "miss_clear");
    frame_start = 1'b0;
    check1("miss_cleared", disp_miss, 1'b0);

    // Out-of-range write is acknowledged but dropped.
    check1("oob_before", err_oob, 1'b0);
    cl_addr[2]  = 19'd76800;
    cl_wdata[2] = 24'hDEAD01;
    req_valid   = 3'b100;
    req_we      = 3'b100;
    tick(3'b100, 1'b0, "oob_wr");
    check1("oob_set", err_oob, 1'b1);
    frame_start = 1'b1;
    tick(3'b100, 1'b0, "oob_setwins");
    check1("oob_setwins", err_oob, 1'b1);
    req_valid = '0;
    req_we    = '0;
    tick(3'b000, 1'b0, "oob_clear");
    frame_start = 1'b0;
    check1("oob_cleared", err_oob, 1'b0);
    cl_addr[2] = 19'd77000 - 19'd1;
    req_valid  = 3'b100;
    tick(3'b100, 1'b0, "oob_rd_ok");
    req_valid = '0;
    tick(3'b000, 1'b0, "oob_rd_idle");
    check1("oob_rd_noerr", err_oob, 1'b0);
    tick(3'b000, 1'b0, "pre_reset_idle");

    // Reset with a client read in flight: nothing may come back.
    cl_addr[0] = 19'd6;
    req_valid  = 3'b001;
    tick(3'b001, 1'b0, "rst_rd");
    req_valid = '0;
    mon_en    = 1'b0;
    #2;
    Reset_n = 1'b0;
    sbq.delete();
    #1;
    check_zero("reset_mid");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    #2;
    Reset_n   = 1'b1;
    last_addr = '0;
    mon_en    = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 3; k++) tick(3'b000, 1'b0, $sformatf("post_rst%0d", k));
    cl_addr[0] = 19'd600;
    cl_addr[1] = 19'd610;
    cl_addr[2] = 19'd620;
    req_valid  = 3'b111;
    req_we     = 3'b111;
    tick(3'b001, 1'b0, "post_rst_rr0");
    tick(3'b010, 1'b0, "post_rst_rr1");
    req_valid = '0;
    req_we    = '0;
    repeat (3) tick(3'b000, 1'b0, "drain");

    tests++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
